// File: rtl/instr_encoder_if.sv
// Request and memory-write bus of the instruction encoder.
// The slave modport is the encoder itself. The master modport is the
// environment around it: the program-load host plus the memory write port.
interface instr_encoder_if #(
    parameter int AW = 12
);
    logic          req_valid;
    logic          req_ready;
    logic          req_last;
    logic [2:0]    req_type;
    logic [3:0]    req_alu;
    logic [4:0]    req_rd;
    logic [4:0]    req_rs1;
    logic [4:0]    req_rs2;
    logic [31:0]   req_imm;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;

    modport master (
        output req_valid, req_last, req_type, req_alu, req_rd, req_rs1, req_rs2, req_imm,
        output mem_wready,
        input  req_ready, mem_wvalid, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_last, req_type, req_alu, req_rd, req_rs1, req_rs2, req_imm,
        input  mem_wready,
        output req_ready, mem_wvalid, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with program loader.
// Operation requests (type + ALU code + operand fields) are encoded into
// 32-bit words in a registered stage. The words are then buffered in a FIFO
// and written to sequential instruction-memory addresses. A four-state FSM
// frames each load session.
module instr_encoder #(
    parameter int            DEPTH     = 4,
    parameter int            AW        = 12,
    parameter logic [AW-1:0] BASE_ADDR = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    instr_encoder_if.slave      bus,
    output logic                busy,
    output logic                done,
    output logic                enc_err,
    output logic [AW-2:0]       word_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_U = 7'b0110111;
    localparam logic [6:0] OP_S = 7'b0100011;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SRA = 4'b1001;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state, state_nx;

    logic          accept;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          alu_ok;
    logic          is_shift;
    logic [11:0]   imm12;
    logic [31:0]   word_nx;
    logic          legal_nx;

    logic          enc_valid;
    logic [31:0]   enc_word;

    logic [31:0]   fifo_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] occupancy;
    logic          push;
    logic          pop;
    logic [AW-1:0] addr;

    // The word held in the encode stage has a reserved FIFO slot, so it is
    // counted when deciding whether another request may enter.
    assign occupancy     = count + CW'(enc_valid);
    assign bus.req_ready = (state == S_LOAD) && (occupancy < CW'(DEPTH));
    assign accept        = bus.req_valid && bus.req_ready;

    assign push = enc_valid;
    assign pop  = bus.mem_wvalid && bus.mem_wready;

    assign bus.mem_wvalid = (count != '0);
    assign bus.mem_wdata  = bus.mem_wvalid ? fifo_mem[rd_ptr] : '0;
    assign bus.mem_addr   = addr;

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // Map the request fields onto an instruction word and flag illegal requests.
    always_comb begin
        // NOTE: every variable gets a default before the case statements, so no path leaves one unassigned and no latch is inferred.
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        alu_ok   = 1'b1;
        is_shift = 1'b0;
        imm12    = bus.req_imm[11:0];
        word_nx  = '0;
        legal_nx = 1'b0;

        case (bus.req_alu)
            ALU_ADD: funct3 = 3'b000;
            ALU_SUB: begin funct3 = 3'b000; funct7 = 7'b0100000; end
            ALU_SLL: begin funct3 = 3'b001; is_shift = 1'b1; end
            ALU_SLT: funct3 = 3'b010;
            ALU_XOR: funct3 = 3'b100;
            ALU_SRL: begin funct3 = 3'b101; is_shift = 1'b1; end
            ALU_SRA: begin funct3 = 3'b101; funct7 = 7'b0100000; is_shift = 1'b1; end
            ALU_OR:  funct3 = 3'b110;
            ALU_AND: funct3 = 3'b111;
            default: alu_ok = 1'b0;
        endcase

        if (is_shift) begin
            imm12 = {funct7, bus.req_imm[4:0]};
        end

        case (bus.req_type)
            3'b000: begin
                word_nx  = {funct7, bus.req_rs2, bus.req_rs1, funct3, bus.req_rd, OP_R};
                legal_nx = alu_ok;
            end
            3'b011: begin
                word_nx  = {imm12, bus.req_rs1, funct3, bus.req_rd, OP_I};
                legal_nx = alu_ok && (bus.req_alu != ALU_SUB);
            end
            3'b001: begin
                word_nx  = {bus.req_imm[31:12], bus.req_rd, OP_U};
                legal_nx = 1'b1;
            end
            3'b100: begin
                word_nx  = {bus.req_imm[11:5], bus.req_rs2, bus.req_rs1, 3'b010,
                            bus.req_imm[4:0], OP_S};
                legal_nx = 1'b1;
            end
            default: legal_nx = 1'b0;
        endcase
    end

    // Encode stage: capture the accepted word, or pulse the error flag for an illegal request.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments in clocked blocks, so every register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            enc_valid <= 1'b0;
            enc_err   <= 1'b0;
            enc_word  <= '0;
        end else begin
            enc_valid <= accept && legal_nx;
            enc_err   <= accept && !legal_nx;
            if (accept) begin
                enc_word <= word_nx;
            end
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; stale entries are harmless because the empty flag gates the read data.
        if (push) begin
            fifo_mem[wr_ptr] <= enc_word;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Write address and word counter: rewound at session start, advanced per completed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr       <= BASE_ADDR;
            word_count <= '0;
        end else if ((state == S_IDLE) && start) begin
            addr       <= BASE_ADDR;
            word_count <= '0;
        end else if (pop) begin
            addr       <= addr + AW'(4);
            word_count <= word_count + (AW-1)'(1);
        end
    end

    // Session FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Session FSM next state. DRAIN also ends while the final word is
    // being written, so that done follows that write by exactly one cycle.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_LOAD;
            S_LOAD:  if (accept && bus.req_last) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (!enc_valid && ((count == '0) || ((count == CW'(1)) && pop))) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed testbench for instr_encoder.
// Two instances share the request stimulus: the main one (AW=12, base 0)
// and a small one (AW=4, base 0xC) for address wrap. Each has its own start.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_m = 1'b0;
    logic        start_w = 1'b0;
    logic        sel_w = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_last = 1'b0;
    logic [2:0]  req_type = '0;
    logic [3:0]  req_alu = '0;
    logic [4:0]  req_rd = '0;
    logic [4:0]  req_rs1 = '0;
    logic [4:0]  req_rs2 = '0;
    logic [31:0] req_imm = '0;
    logic        mem_wready = 1'b0;

    logic        busy_m, done_m, enc_err_m;
    logic [10:0] wc_m;
    logic        busy_w, done_w, enc_err_w;
    logic [2:0]  wc_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_encoder_if #(.AW(12)) m_if ();
    instr_encoder_if #(.AW(4))  w_if ();

    assign m_if.req_valid  = req_valid && !sel_w;
    assign m_if.req_last   = req_last;
    assign m_if.req_type   = req_type;
    assign m_if.req_alu    = req_alu;
    assign m_if.req_rd     = req_rd;
    assign m_if.req_rs1    = req_rs1;
    assign m_if.req_rs2    = req_rs2;
    assign m_if.req_imm    = req_imm;
    assign m_if.mem_wready = mem_wready;

    assign w_if.req_valid  = req_valid && sel_w;
    assign w_if.req_last   = req_last;
    assign w_if.req_type   = req_type;
    assign w_if.req_alu    = req_alu;
    assign w_if.req_rd     = req_rd;
    assign w_if.req_rs1    = req_rs1;
    assign w_if.req_rs2    = req_rs2;
    assign w_if.req_imm    = req_imm;
    assign w_if.mem_wready = mem_wready;

    instr_encoder #(.DEPTH(4), .AW(12), .BASE_ADDR(12'h000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start_m), .bus(m_if),
        .busy(busy_m), .done(done_m), .enc_err(enc_err_m), .word_count(wc_m)
    );

    instr_encoder #(.DEPTH(4), .AW(4), .BASE_ADDR(4'hC)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(start_w), .bus(w_if),
        .busy(busy_w), .done(done_w), .enc_err(enc_err_w), .word_count(wc_w)
    );

    // Write / pulse monitors, sampled on the falling edge.
    int unsigned  cycle = 0;
    logic [31:0]  wr_data [$];
    logic [11:0]  wr_addr [$];
    int unsigned  wr_cyc  [$];
    logic [31:0]  ww_data [$];
    logic [3:0]   ww_addr [$];
    int           done_cnt = 0;
    int           err_cnt = 0;

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (m_if.mem_wvalid && mem_wready) begin
                wr_data.push_back(m_if.mem_wdata);
                wr_addr.push_back(m_if.mem_addr);
                wr_cyc.push_back(cycle);
            end
            if (w_if.mem_wvalid && mem_wready) begin
                ww_data.push_back(w_if.mem_wdata);
                ww_addr.push_back(w_if.mem_addr);
            end
            if (done_m) done_cnt++;
            if (enc_err_m) err_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit w);
        if (w) start_w = 1'b1;
        else   start_m = 1'b1;
        tick();
        start_m = 1'b0;
        start_w = 1'b0;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input logic [2:0] t, input logic [3:0] alu, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last);
        bit ok = 1'b0;
        req_type  = t;
        req_alu   = alu;
        req_rd    = rd;
        req_rs1   = rs1;
        req_rs2   = rs2;
        req_imm   = imm;
        req_last  = last;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sel_w ? w_if.req_ready : m_if.req_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("req_accept", 32'(ok), 32'd1);
        tick();
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic wait_done(input bit w);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (w ? done_w : done_m) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("done_seen", 32'(ok), 32'd1);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int d0;
        int e0;
        logic [31:0] burst_exp [4];
        logic [31:0] bp_exp    [6];
        burst_exp = '{32'h407302B3, 32'h40315093, 32'h12345237, 32'h00532423};
        bp_exp    = '{32'h003140B3, 32'h00316133, 32'h003121B3,
                      32'h00511213, 32'hFFF17293, 32'h00315333};

        // Reset state
        tick();
        tick();
        check("rst_req_ready", m_if.req_ready, 0);
        check("rst_wvalid", m_if.mem_wvalid, 0);
        check("rst_addr", m_if.mem_addr, 0);
        check("rst_wdata", m_if.mem_wdata, 0);
        check("rst_busy_done_err", {busy_m, done_m, enc_err_m}, 0);
        check("rst_word_count", wc_m, 0);
        check("rst_wrap_addr", w_if.mem_addr, 4'hC);
        rst_n = 1'b1;
        tick();

        // Single ADD x1,x2,x3 with exact latency
        mem_wready = 1'b1;
        pulse_start(1'b0);
        check("load_busy", busy_m, 1);
        send(3'b000, 4'b0010, 5'd1, 5'd2, 5'd3, 32'h0, 1'b1);
        check("add_n1_wvalid", m_if.mem_wvalid, 0);
        tick();
        check("add_n2_wvalid", m_if.mem_wvalid, 1);
        check("add_wdata", m_if.mem_wdata, 32'h003100B3);
        check("add_addr", m_if.mem_addr, 0);
        tick();
        check("add_done", done_m, 1);
        check("add_word_count", wc_m, 1);
        check("add_addr_next", m_if.mem_addr, 4);
        tick();
        check("add_done_fall", done_m, 0);
        check("add_busy_fall", busy_m, 0);

        // Mixed burst, memory always ready
        b = wr_data.size();
        pulse_start(1'b0);
        send(3'b000, 4'b0100, 5'd5, 5'd6, 5'd7, 32'h0, 1'b0);          // SUB x5,x6,x7
        send(3'b011, 4'b1001, 5'd1, 5'd2, 5'd0, 32'h3, 1'b0);          // SRAI x1,x2,3
        send(3'b001, 4'b1111, 5'd4, 5'd0, 5'd0, 32'h12345000, 1'b0);   // LUI x4,0x12345
        send(3'b100, 4'b1111, 5'd0, 5'd6, 5'd5, 32'h8, 1'b1);          // SW x5,8(x6)
        wait_done(1'b0);
        check("burst_word_count", wc_m, 4);
        check("burst_nwrites", wr_data.size() - b, 4);
        if (wr_data.size() - b == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("burst_data%0d", i), wr_data[b+i], burst_exp[i]);
                check($sformatf("burst_addr%0d", i), wr_addr[b+i], 32'(4*i));
                check($sformatf("burst_cycle%0d", i), wr_cyc[b+i] - wr_cyc[b], i);
            end
        end
        tick();

        // Backpressure: 6 requests into a 4-deep FIFO with memory stalled
        mem_wready = 1'b0;
        b = wr_data.size();
        pulse_start(1'b0);
        send(3'b000, 4'b0111, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);          // XOR x1,x2,x3
        send(3'b000, 4'b0001, 5'd2, 5'd2, 5'd3, 32'h0, 1'b0);          // OR  x2,x2,x3
        send(3'b000, 4'b1000, 5'd3, 5'd2, 5'd3, 32'h0, 1'b0);          // SLT x3,x2,x3
        send(3'b011, 4'b0011, 5'd4, 5'd2, 5'd0, 32'h5, 1'b0);          // SLLI x4,x2,5
        check("bp_ready_low", m_if.req_ready, 0);
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_wvalid", m_if.mem_wvalid, 1);
            check("bp_stall_wdata", m_if.mem_wdata, 32'h003140B3);
            check("bp_stall_addr", m_if.mem_addr, 0);
            tick();
        end
        mem_wready = 1'b1;
        send(3'b011, 4'b0000, 5'd5, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b0);   // ANDI x5,x2,-1
        send(3'b000, 4'b0101, 5'd6, 5'd2, 5'd3, 32'h0, 1'b1);          // SRL x6,x2,x3
        wait_done(1'b0);
        check("bp_word_count", wc_m, 6);
        check("bp_nwrites", wr_data.size() - b, 6);
        if (wr_data.size() - b == 6) begin
            for (int i = 0; i < 6; i++) begin
                check($sformatf("bp_data%0d", i), wr_data[b+i], bp_exp[i]);
                check($sformatf("bp_addr%0d", i), wr_addr[b+i], 32'(4*i));
            end
        end
        tick();

        // Illegal requests: undefined type, then I-type SUB carrying last
        b  = wr_data.size();
        e0 = err_cnt;
        d0 = done_cnt;
        pulse_start(1'b0);
        send(3'b111, 4'b0010, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        check("ill_type_err", enc_err_m, 1);
        tick();
        check("ill_err_one_cycle", enc_err_m, 0);
        send(3'b011, 4'b0100, 5'd1, 5'd2, 5'd0, 32'h1, 1'b1);
        check("ill_isub_err", enc_err_m, 1);
        wait_done(1'b0);
        check("ill_word_count", wc_m, 0);
        tick();
        check("ill_nwrites", wr_data.size() - b, 0);
        check("ill_err_pulses", err_cnt - e0, 2);
        check("ill_done_pulses", done_cnt - d0, 1);

        // Address wrap on the AW=4 instance
        sel_w = 1'b1;
        pulse_start(1'b1);
        send(3'b000, 4'b0010, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        send(3'b000, 4'b0010, 5'd2, 5'd2, 5'd3, 32'h0, 1'b1);
        wait_done(1'b1);
        check("wrap_word_count", wc_w, 2);
        tick();
        sel_w = 1'b0;
        check("wrap_nwrites", ww_data.size(), 2);
        if (ww_data.size() == 2) begin
            check("wrap_addr0", ww_addr[0], 4'hC);
            check("wrap_addr1", ww_addr[1], 4'h0);
            check("wrap_data0", ww_data[0], 32'h003100B3);
            check("wrap_data1", ww_data[1], 32'h00310133);
        end

        // Reset while draining three buffered words
        mem_wready = 1'b0;
        d0 = done_cnt;
        pulse_start(1'b0);
        send(3'b000, 4'b0010, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        send(3'b000, 4'b0010, 5'd2, 5'd2, 5'd3, 32'h0, 1'b0);
        send(3'b000, 4'b0010, 5'd3, 5'd2, 5'd3, 32'h0, 1'b1);
        tick();
        check("mid_wvalid_before", m_if.mem_wvalid, 1);
        check("mid_busy_before", busy_m, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_wvalid_reset", m_if.mem_wvalid, 0);
        check("mid_busy_reset", busy_m, 0);
        check("mid_addr_reset", m_if.mem_addr, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_no_done", done_cnt - d0, 0);
        check("mid_wvalid_after", m_if.mem_wvalid, 0);
        mem_wready = 1'b1;
        b = wr_data.size();
        pulse_start(1'b0);
        send(3'b000, 4'b0100, 5'd5, 5'd6, 5'd7, 32'h0, 1'b1);
        wait_done(1'b0);
        check("mid_restart_nwrites", wr_data.size() - b, 1);
        if (wr_data.size() - b == 1) begin
            check("mid_restart_addr", wr_addr[b], 0);
            check("mid_restart_data", wr_data[b], 32'h407302B3);
        end
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
